// File: rtl/cpu_controller.sv
// Instruction-sequencing controller for the simple RISC CPU: fetch/decode/execute
// state machine that drives all datapath, PC, IR, address and memory-command controls.
module cpu_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr_in,
    output logic [2:0]  readnum,
    output logic [2:0]  writenum,
    output logic        write,
    output logic        loada,
    output logic        loadb,
    output logic        loadc,
    output logic        loads,
    output logic        asel,
    output logic        bsel,
    output logic [1:0]  ALUop,
    output logic [1:0]  shift,
    output logic [1:0]  vsel,
    output logic [15:0] sximm8,
    output logic [15:0] sximm5,
    output logic        load_ir,
    output logic        load_pc,
    output logic        reset_pc,
    output logic        load_addr,
    output logic        addr_sel,
    output logic [1:0]  mem_cmd,
    output logic        halt
);

    localparam int unsigned REG_W = 3;
    localparam int unsigned SEL_W = 2;

    localparam logic [SEL_W-1:0] MEM_NONE  = 2'b00;
    localparam logic [SEL_W-1:0] MEM_READ  = 2'b01;
    localparam logic [SEL_W-1:0] MEM_WRITE = 2'b10;

    localparam logic [SEL_W-1:0] VSEL_MDATA = 2'b00;
    localparam logic [SEL_W-1:0] VSEL_IMM8  = 2'b01;
    localparam logic [SEL_W-1:0] VSEL_C     = 2'b11;

    typedef enum logic [3:0] {
        S_RST,
        S_IF1,
        S_IF2,
        S_UPDATE_PC,
        S_DECODE,
        S_GET_A,
        S_GET_B,
        S_EXEC,
        S_WRITE_IMM,
        S_WRITE_C,
        S_ADDR,
        S_LOAD_ADDR,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_HALT
    } state_e;

    state_e state_q, state_d;

    logic [2:0]       opcode;
    logic [1:0]       op;
    logic [REG_W-1:0] rn, rd, rm;
    logic [1:0]       sh;

    assign opcode = instr_in[15:13];
    assign op     = instr_in[12:11];
    assign rn     = instr_in[10:8];
    assign rd     = instr_in[7:5];
    assign sh     = instr_in[4:3];
    assign rm     = instr_in[2:0];

    assign sximm8 = {{8{instr_in[7]}}, instr_in[7:0]};
    assign sximm5 = {{11{instr_in[4]}}, instr_in[4:0]};

    // Instruction classes; anything not matched below is treated as HALT.
    logic is_movi, is_movr, is_alu, is_cmp, is_mvn, is_ldr, is_str;

    assign is_movi = (opcode == 3'b110) && (op == 2'b10);
    assign is_movr = (opcode == 3'b110) && (op == 2'b00);
    assign is_alu  = (opcode == 3'b101);
    assign is_cmp  = is_alu && (op == 2'b01);
    assign is_mvn  = is_alu && (op == 2'b11);
    assign is_ldr  = (opcode == 3'b011) && (op == 2'b00);
    assign is_str  = (opcode == 3'b100) && (op == 2'b00);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        readnum   = '0;
        writenum  = '0;
        write     = 1'b0;
        loada     = 1'b0;
        loadb     = 1'b0;
        loadc     = 1'b0;
        loads     = 1'b0;
        asel      = 1'b0;
        bsel      = 1'b0;
        ALUop     = 2'b00;
        shift     = 2'b00;
        vsel      = VSEL_MDATA;
        load_ir   = 1'b0;
        load_pc   = 1'b0;
        reset_pc  = 1'b0;
        load_addr = 1'b0;
        addr_sel  = 1'b0;
        mem_cmd   = MEM_NONE;
        halt      = 1'b0;

        case (state_q)
            S_RST: begin
                reset_pc = 1'b1;
                load_pc  = 1'b1;
                state_d  = S_IF1;
            end
            S_IF1: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                state_d  = S_IF2;
            end
            S_IF2: begin
                addr_sel = 1'b1;
                mem_cmd  = MEM_READ;
                load_ir  = 1'b1;
                state_d  = S_UPDATE_PC;
            end
            S_UPDATE_PC: begin
                load_pc = 1'b1;
                state_d = S_DECODE;
            end
            S_DECODE: begin
                if (is_movi)                state_d = S_WRITE_IMM;
                else if (is_movr || is_mvn) state_d = S_GET_B;
                else if (is_alu)            state_d = S_GET_A;
                else if (is_ldr || is_str)  state_d = S_GET_A;
                else                        state_d = S_HALT;
            end
            S_GET_A: begin
                readnum = rn;
                loada   = 1'b1;
                state_d = (is_ldr || is_str) ? S_ADDR : S_GET_B;
            end
            S_GET_B: begin
                readnum = is_str ? rd : rm;
                loadb   = 1'b1;
                state_d = S_EXEC;
            end
            S_EXEC: begin
                shift = is_str ? 2'b00 : sh;
                ALUop = is_alu ? op : 2'b00;
                asel  = is_movr || is_mvn || is_str;
                // CMP only updates status; all other ops capture the result in C.
                if (is_cmp) begin
                    loads   = 1'b1;
                    state_d = S_IF1;
                end else begin
                    loadc   = 1'b1;
                    state_d = is_str ? S_MEM_WR : S_WRITE_C;
                end
            end
            S_WRITE_IMM: begin
                vsel     = VSEL_IMM8;
                writenum = rn;
                write    = 1'b1;
                state_d  = S_IF1;
            end
            S_WRITE_C: begin
                vsel     = VSEL_C;
                writenum = rd;
                write    = 1'b1;
                state_d  = S_IF1;
            end
            S_ADDR: begin
                bsel    = 1'b1;
                loadc   = 1'b1;
                state_d = S_LOAD_ADDR;
            end
            S_LOAD_ADDR: begin
                load_addr = 1'b1;
                state_d   = is_str ? S_GET_B : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_cmd = MEM_READ;
                state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                mem_cmd  = MEM_READ;
                vsel     = VSEL_MDATA;
                writenum = rd;
                write    = 1'b1;
                state_d  = S_IF1;
            end
            S_MEM_WR: begin
                mem_cmd = MEM_WRITE;
                state_d = S_IF1;
            end
            S_HALT: begin
                halt    = 1'b1;
                state_d = S_HALT;
            end
            default: state_d = S_RST;
        endcase

        // Suppress every side-effecting strobe while reset is held, whatever the state.
        if (reset) begin
            write     = 1'b0;
            loada     = 1'b0;
            loadb     = 1'b0;
            loadc     = 1'b0;
            loads     = 1'b0;
            load_ir   = 1'b0;
            load_addr = 1'b0;
            mem_cmd   = MEM_NONE;
        end
    end

endmodule

// File: tb/tb_cpu_controller.sv
// Self-checking bench for cpu_controller: directed and random instructions compared
// cycle by cycle against a per-instruction control-sequence model.
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic [15:0] instr_in;
    logic [2:0]  readnum, writenum;
    logic        write, loada, loadb, loadc, loads, asel, bsel;
    logic [1:0]  ALUop, shift, vsel, mem_cmd;
    logic [15:0] sximm8, sximm5;
    logic        load_ir, load_pc, reset_pc, load_addr, addr_sel, halt;

    cpu_controller dut (
        .clk(clk), .reset(reset), .instr_in(instr_in),
        .readnum(readnum), .writenum(writenum), .write(write),
        .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
        .asel(asel), .bsel(bsel), .ALUop(ALUop), .shift(shift), .vsel(vsel),
        .sximm8(sximm8), .sximm5(sximm5),
        .load_ir(load_ir), .load_pc(load_pc), .reset_pc(reset_pc),
        .load_addr(load_addr), .addr_sel(addr_sel), .mem_cmd(mem_cmd), .halt(halt)
    );

    typedef struct packed {
        logic [2:0] readnum;
        logic [2:0] writenum;
        logic       write, loada, loadb, loadc, loads, asel, bsel;
        logic [1:0] aluop, shift, vsel;
        logic       load_ir, load_pc, reset_pc, load_addr, addr_sel;
        logic [1:0] mem_cmd;
        logic       halt;
    } ctl_t;

    int   n_cmp  = 0;
    int   n_fail = 0;
    ctl_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t observed();
        ctl_t c;
        c.readnum = readnum;   c.writenum = writenum; c.write = write;
        c.loada = loada;       c.loadb = loadb;       c.loadc = loadc;
        c.loads = loads;       c.asel = asel;         c.bsel = bsel;
        c.aluop = ALUop;       c.shift = shift;       c.vsel = vsel;
        c.load_ir = load_ir;   c.load_pc = load_pc;   c.reset_pc = reset_pc;
        c.load_addr = load_addr; c.addr_sel = addr_sel;
        c.mem_cmd = mem_cmd;   c.halt = halt;
        return c;
    endfunction

    task automatic chk(input ctl_t e, input string tag);
        ctl_t o;
        o = observed();
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    task automatic chk16(input logic [15:0] o, input logic [15:0] e, input string tag);
        n_cmp++;
        assert (o === e) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, o, e);
        end
    endtask

    // Strobes that must read low whenever reset is high.
    function automatic ctl_t under_reset(input ctl_t c);
        ctl_t r;
        r = c;
        r.write = 1'b0; r.loada = 1'b0; r.loadb = 1'b0; r.loadc = 1'b0;
        r.loads = 1'b0; r.load_ir = 1'b0; r.load_addr = 1'b0; r.mem_cmd = 2'b00;
        return r;
    endfunction

    function automatic ctl_t rst_vec();
        ctl_t c;
        c = '0; c.reset_pc = 1'b1; c.load_pc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t halt_vec();
        ctl_t c;
        c = '0; c.halt = 1'b1;
        return c;
    endfunction

    function automatic ctl_t get_reg(input logic [2:0] r, input bit is_a);
        ctl_t c;
        c = '0; c.readnum = r;
        if (is_a) c.loada = 1'b1; else c.loadb = 1'b1;
        return c;
    endfunction

    function automatic ctl_t exec_vec(input logic [1:0] sh, input logic [1:0] alu,
                                      input bit a0, input bit status_only);
        ctl_t c;
        c = '0; c.shift = sh; c.aluop = alu; c.asel = a0;
        if (status_only) c.loads = 1'b1; else c.loadc = 1'b1;
        return c;
    endfunction

    function automatic ctl_t wr_vec(input logic [2:0] r, input logic [1:0] src, input logic [1:0] mc);
        ctl_t c;
        c = '0; c.writenum = r; c.vsel = src; c.write = 1'b1; c.mem_cmd = mc;
        return c;
    endfunction

    // Expected control sequence from the IF1 of this instruction up to the cycle before the next IF1.
    task automatic model(input logic [15:0] ins);
        logic [2:0] opc, rn, rd, rm;
        logic [1:0] op, sh;
        ctl_t c;
        opc = ins[15:13]; op = ins[12:11];
        rn = ins[10:8]; rd = ins[7:5]; sh = ins[4:3]; rm = ins[2:0];
        exp_q.delete();
        c = '0; c.addr_sel = 1'b1; c.mem_cmd = 2'b01; exp_q.push_back(c);
        c.load_ir = 1'b1;                              exp_q.push_back(c);
        c = '0; c.load_pc = 1'b1;                      exp_q.push_back(c);
        c = '0;                                        exp_q.push_back(c);
        if (opc == 3'd6 && op == 2'd2) begin
            exp_q.push_back(wr_vec(rn, 2'b01, 2'b00));
        end else if (opc == 3'd6 && op == 2'd0) begin
            exp_q.push_back(get_reg(rm, 1'b0));
            exp_q.push_back(exec_vec(sh, 2'b00, 1'b1, 1'b0));
            exp_q.push_back(wr_vec(rd, 2'b11, 2'b00));
        end else if (opc == 3'd5) begin
            if (op != 2'd3) exp_q.push_back(get_reg(rn, 1'b1));
            exp_q.push_back(get_reg(rm, 1'b0));
            exp_q.push_back(exec_vec(sh, op, op == 2'd3, op == 2'd1));
            if (op != 2'd1) exp_q.push_back(wr_vec(rd, 2'b11, 2'b00));
        end else if ((opc == 3'd3 || opc == 3'd4) && op == 2'd0) begin
            exp_q.push_back(get_reg(rn, 1'b1));
            c = '0; c.bsel = 1'b1; c.loadc = 1'b1; exp_q.push_back(c);
            c = '0; c.load_addr = 1'b1;            exp_q.push_back(c);
            if (opc == 3'd3) begin
                c = '0; c.mem_cmd = 2'b01; exp_q.push_back(c);
                exp_q.push_back(wr_vec(rd, 2'b00, 2'b01));
            end else begin
                exp_q.push_back(get_reg(rd, 1'b0));
                exp_q.push_back(exec_vec(2'b00, 2'b00, 1'b1, 1'b0));
                c = '0; c.mem_cmd = 2'b10; exp_q.push_back(c);
            end
        end else begin
            exp_q.push_back(halt_vec());
        end
    endtask

    // Entered #1 after the edge that begins IF1; returns #1 after the edge that begins the next IF1.
    task automatic run_instr(input logic [15:0] ins, input int stop_at);
        ctl_t e;
        string tag;
        model(ins);
        instr_in = ins;
        @(negedge clk);
        chk16(sximm8, 16'($signed(ins[7:0])), "sximm8");
        chk16(sximm5, 16'($signed(ins[4:0])), "sximm5");
        for (int i = 0; i < exp_q.size() && i < stop_at; i++) begin
            e = exp_q[i];
            if (i > 0) @(negedge clk);
            tag = $sformatf("ins%h_cyc%0d", ins, i);
            chk(e, tag);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset(input ctl_t cur);
        reset = 1'b1;
        @(negedge clk);
        chk(under_reset(cur), "reset_forced");
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk(rst_vec(), "rst_state");
        @(posedge clk); #1;
    endtask

    task automatic run_halt(input logic [15:0] ins);
        run_instr(ins, 4);
        for (int i = 0; i < 22; i++) begin
            @(negedge clk);
            chk(halt_vec(), "halt_hold");
            @(posedge clk); #1;
        end
        do_reset(halt_vec());
    endtask

    function automatic logic [15:0] rand_instr();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom_range(0, 7))
            0: r[15:11] = 5'b11010;
            1: r[15:11] = 5'b11000;
            2: r[15:11] = 5'b10100;
            3: r[15:11] = 5'b10101;
            4: r[15:11] = 5'b10110;
            5: r[15:11] = 5'b10111;
            6: r[15:11] = 5'b01100;
            default: r[15:11] = 5'b10000;
        endcase
        return r;
    endfunction

    initial begin
        reset    = 1'b1;
        instr_in = 16'h0000;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk(rst_vec(), "rst_first");
        @(posedge clk); #1;

        run_instr(16'hD1FE, 99);
        run_instr(16'hA148, 99);
        run_instr(16'hA900, 99);
        run_instr(16'h617F, 99);
        run_instr(16'h8162, 99);

        // Reset arriving in the EXEC cycle of an ADD.
        run_instr(16'hA148, 6);
        do_reset(exp_q[6]);

        for (int n = 0; n < 150; n++) begin
            run_instr(rand_instr(), 99);
        end

        run_halt(16'hE000);
        run_halt(16'h0000);
        run_instr(16'hD07F, 99);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
